// File: rtl/except_ctrl.sv
// -----------------------------------------------------------------------------
// except_ctrl
//
// MEM-stage exception arbiter and pipeline-redirect controller. It sits
// directly upstream of the CP0 register file.
//
// Each cycle it ranks the raw exception flags of the MEM-stage instruction
// against pending interrupts. The interrupt check uses CP0 Status/Cause/EPC
// values with any in-flight WB-stage CP0 write forwarded in. The winning
// exception code, the faulting PC and the delay-slot flag go to CP0.
//
// Once an exception is taken, the controller holds flush_o for FLUSH_CYCLES
// cycles. During that time new_pc_o carries either the exception vector or,
// for ERET, the EPC.
//
// Parameters
//   EXC_VECTOR    redirect target for every exception except ERET
//   FLUSH_CYCLES  cycles flush_o stays high after a commit (legal 1..15)
//
// Ports
//   clk                  clock, rising edge
//   rst                  asynchronous, active-low reset
//   mem_valid_i          MEM stage holds a real instruction
//   mem_pc_i             PC of the MEM-stage instruction
//   mem_in_delayslot_i   MEM instruction sits in a branch delay slot
//   mem_exc_i            raw flags: [0] syscall, [1] break, [2] RI,
//                        [3] overflow, [4] trap, [5] eret
//   cp0_status_i         current CP0 Status
//   cp0_cause_i          current CP0 Cause
//   cp0_epc_i            current CP0 EPC
//   wb_cp0_we_i          WB-stage CP0 write enable
//   wb_cp0_waddr_i       WB-stage CP0 write address (12/13/14)
//   wb_cp0_data_i        WB-stage CP0 write data
//   excepttype_o         exception code to CP0 (combinational)
//   current_inst_addr_o  faulting PC to CP0 (pass-through)
//   is_in_delayslot_o    delay-slot flag to CP0 (pass-through)
//   flush_o              squash IF..MEM and load new_pc_o (registered)
//   new_pc_o             redirect target (registered)
// -----------------------------------------------------------------------------
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [5:0]  mem_exc_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        wb_cp0_we_i,
    input  logic [4:0]  wb_cp0_waddr_i,
    input  logic [31:0] wb_cp0_data_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [4:0]  CP0_STATUS_ADDR = 5'd12;   // Status, Cause, EPC are consecutive
    localparam int unsigned NUM_FWD         = 3;

    localparam logic [31:0] CODE_NONE = 32'h0;
    localparam logic [31:0] CODE_INT  = 32'h1;
    localparam logic [31:0] CODE_SYS  = 32'h8;
    localparam logic [31:0] CODE_BP   = 32'h9;
    localparam logic [31:0] CODE_RI   = 32'hA;
    localparam logic [31:0] CODE_OV   = 32'hC;
    localparam logic [31:0] CODE_TR   = 32'hD;
    localparam logic [31:0] CODE_ERET = 32'hE;

    // The counter reloads with FLUSH_CYCLES-1. The exit happens in the cycle
    // where it reads zero, so flush_o is high for exactly FLUSH_CYCLES cycles.
    localparam logic [3:0]  CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    // Flag bit positions inside mem_exc_i
    localparam int EXC_SYS  = 0;
    localparam int EXC_BP   = 1;
    localparam int EXC_RI   = 2;
    localparam int EXC_OV   = 3;
    localparam int EXC_TR   = 4;
    localparam int EXC_ERET = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t      state_reg,  state_next;
    logic [3:0]  cnt_reg,    cnt_next;
    logic        flush_reg,  flush_next;
    logic [31:0] new_pc_reg, new_pc_next;

    logic [NUM_FWD-1:0] wb_hit;        // [0] Status, [1] Cause, [2] EPC
    logic [31:0]        status_eff;
    logic [31:0]        cause_eff;
    logic [31:0]        epc_eff;
    logic               int_req;
    logic [31:0]        arb_code;
    logic               arb_enable;
    logic               unused_bits;

    // -------------------------------------------------------------------------
    // WB -> MEM CP0 forwarding
    // One address match per forwarded register.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_FWD; gi++) begin : g_fwd_hit
            assign wb_hit[gi] = wb_cp0_we_i &&
                                (wb_cp0_waddr_i == (CP0_STATUS_ADDR + 5'(gi)));
        end
    endgenerate

    assign status_eff = wb_hit[0] ? wb_cp0_data_i : cp0_status_i;
    assign epc_eff    = wb_hit[2] ? wb_cp0_data_i : cp0_epc_i;

    // Only the software-interrupt bits IP[1:0] of Cause are writable by
    // software. The hardware interrupt lines IP[7:2] always come from CP0.
    assign cause_eff = {cp0_cause_i[31:10],
                        wb_hit[1] ? wb_cp0_data_i[9:8] : cp0_cause_i[9:8],
                        cp0_cause_i[7:0]};

    // Interrupt request: an unmasked pending line, with IE set and EXL clear.
    // This is level-sensitive and is re-evaluated every cycle.
    assign int_req = ((cause_eff[15:8] & status_eff[15:8]) != 8'h00) &&
                     status_eff[0] && !status_eff[1];

    // Register bits that take no part in the interrupt decision
    assign unused_bits = ^{cause_eff[31:16], cause_eff[7:0],
                           status_eff[31:16], status_eff[7:2]};

    // -------------------------------------------------------------------------
    // Priority arbitration.
    // The interrupt outranks every synchronous flag, so the interrupted
    // instruction is simply re-executed after the handler returns.
    // -------------------------------------------------------------------------
    always_comb begin
        arb_code = CODE_NONE;
        if (int_req)                  arb_code = CODE_INT;
        else if (mem_exc_i[EXC_RI])   arb_code = CODE_RI;
        else if (mem_exc_i[EXC_OV])   arb_code = CODE_OV;
        else if (mem_exc_i[EXC_TR])   arb_code = CODE_TR;
        else if (mem_exc_i[EXC_SYS])  arb_code = CODE_SYS;
        else if (mem_exc_i[EXC_BP])   arb_code = CODE_BP;
        else if (mem_exc_i[EXC_ERET]) arb_code = CODE_ERET;
    end

    // Arbitration happens only for a real instruction while IDLE. Holding it
    // off during reset keeps CP0 from sampling a code while rst is low.
    assign arb_enable   = rst && (state_reg == IDLE) && mem_valid_i;
    assign excepttype_o = arb_enable ? arb_code : CODE_NONE;

    // CP0 qualifies these with excepttype_o, so they need no gating here.
    assign current_inst_addr_o = mem_pc_i;
    assign is_in_delayslot_o   = mem_in_delayslot_i;

    // -------------------------------------------------------------------------
    // Redirect FSM: next state and next register values
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        flush_next  = flush_reg;
        new_pc_next = new_pc_reg;

        case (state_reg)
            IDLE: begin
                if (excepttype_o != CODE_NONE) begin
                    state_next  = FLUSH;
                    cnt_next    = CNT_LOAD;
                    flush_next  = 1'b1;
                    new_pc_next = (excepttype_o == CODE_ERET) ? epc_eff : EXC_VECTOR;
                end
            end

            FLUSH: begin
                // Any flags seen here belong to squashed instructions.
                if (cnt_reg == 4'd0) begin
                    state_next = IDLE;
                    flush_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
                flush_next = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers.
    // The asynchronous reset drops flush_o immediately, even mid-flush.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            flush_reg  <= 1'b0;
            new_pc_reg <= 32'h0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            flush_reg  <= flush_next;
            new_pc_reg <= new_pc_next;
        end
    end

    assign flush_o  = flush_reg;
    assign new_pc_o = new_pc_reg;

endmodule

// File: doc/except_ctrl.md
# except_ctrl

Exception arbitration and pipeline-redirect controller in the MEM stage, directly upstream of the CP0 register file. Each cycle it prioritises the raw exception flags of the MEM-stage instruction against pending interrupts. It uses CP0 Status/Cause/EPC values forwarded from any in-flight WB-stage CP0 write, and drives the encoded exception type, faulting PC and delay-slot flag into CP0. After committing an exception it runs a flush sequence that redirects the PC to the exception vector or EPC and squashes younger instructions.

## Interface
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except ERET
- FLUSH_CYCLES, 2, cycles flush_o is held after an exception commits (legal values 1..15)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc_i  in  32  PC of MEM-stage instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_exc_i  in  6  raw flags: [0] syscall, [1] break, [2] reserved instruction, [3] overflow, [4] trap, [5] eret
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current CP0 register values
- wb_cp0_we_i  in  1  WB-stage CP0 write enable
- wb_cp0_waddr_i  in  5  WB-stage CP0 write address (12 Status, 13 Cause, 14 EPC)
- wb_cp0_data_i  in  32  WB-stage CP0 write data
- excepttype_o  out  32  exception code to CP0
- current_inst_addr_o  out  32  faulting PC to CP0
- is_in_delayslot_o  out  1  delay-slot flag to CP0
- flush_o  out  1  squash IF..MEM and load new_pc_o
- new_pc_o  out  32  redirect target

## Operation
- Forwarding, all combinational:
  - status_eff = wb_cp0_data_i if wb_cp0_we_i and waddr == 12, else cp0_status_i.
  - epc_eff uses the same rule with waddr 14.
  - cause_eff = cp0_cause_i with bits [9:8] replaced by wb_cp0_data_i[9:8] when wb_cp0_we_i and waddr == 13.
- int_req = (cause_eff[15:8] & status_eff[15:8]) != 0 && status_eff[0] && !status_eff[1].
- Arbitration applies only in state IDLE with mem_valid_i = 1. Fixed priority, first match wins:
  - int_req → 32'h1
  - RI → 32'hA
  - overflow → 32'hC
  - trap → 32'hD
  - syscall → 32'h8
  - break → 32'h9
  - eret → 32'hE
  - none → 32'h0
- excepttype_o is combinational and is 0 whenever state != IDLE or mem_valid_i = 0.
- current_inst_addr_o = mem_pc_i and is_in_delayslot_o = mem_in_delayslot_i. Both pass through unconditionally; CP0 gates on excepttype_o.
- FSM states IDLE and FLUSH, plus a 4-bit counter cnt.
  - IDLE → FLUSH when excepttype_o != 0.
  - On that transition: latch new_pc_o = (code == 32'hE) ? epc_eff : EXC_VECTOR, and load cnt = FLUSH_CYCLES - 1.
  - In FLUSH: flush_o = 1. cnt decrements each cycle. FLUSH → IDLE in the cycle where cnt == 0.
- Interrupts are level-sensitive and are never latched. An interrupt pending during a bubble is taken on the next valid instruction in IDLE.

## Timing
- Reset (asynchronous, rst = 0):
  - state = IDLE, cnt = 0, flush_o = 0, new_pc_o = 0.
  - excepttype_o = 0 while rst is low.
- Exception detected in cycle T:
  - excepttype_o is valid in T, and CP0 samples it at the edge ending T.
  - flush_o = 1 and new_pc_o are valid in cycles T+1 .. T+FLUSH_CYCLES.
  - The first new arbitration is possible in T+FLUSH_CYCLES+1.
- Flags arriving during FLUSH are ignored; those instructions are squashed.
- A WB write to Status in cycle T affects int_req in T itself, through forwarding. Example: a WB write that sets EXL suppresses an interrupt in the same cycle.
- Simultaneous int_req and a synchronous flag: the interrupt wins and the instruction is re-executed after the return.
- If rst asserts mid-FLUSH, flush_o drops immediately (asynchronously).
- flush_o and new_pc_o are registered. excepttype_o and the pass-through outputs are combinational.

## Test plan
- Overflow with mem_valid_i = 1, mem_pc_i = 32'h8000_0100, no delay slot:
  - Cycle T: excepttype_o = 32'hC, current_inst_addr_o = 32'h8000_0100.
  - T+1, T+2: flush_o = 1, new_pc_o = 32'hBFC0_0380.
  - T+3: flush_o = 0.
- ERET while a WB write of EPC = 32'h8000_0200 is in flight (cp0_epc_i = 32'h0):
  - excepttype_o = 32'hE, new_pc_o = 32'h8000_0200.
- cp0_status_i = 32'h0000_0401, cp0_cause_i[10] = 1, syscall also flagged:
  - excepttype_o = 32'h1, not 32'h8.
- Same interrupt setup, but the WB stage writes Status = 32'h0000_0403 in the same cycle:
  - EXL is now set, so excepttype_o = 32'h8.
- RI flagged during the cycle after an exception (state FLUSH):
  - excepttype_o = 0 and no new latch.
  - Then rst pulsed low in the 2nd flush cycle: flush_o = 0 and new_pc_o = 0 immediately.
- Interrupt pending while mem_valid_i = 0 for 3 cycles:
  - excepttype_o = 0 throughout.
  - On the first cycle with mem_valid_i = 1: excepttype_o = 32'h1 and is_in_delayslot_o follows mem_in_delayslot_i.
